// File: rtl/i2s_tx_master_tdm.sv
// i2s_tx_master_tdm: parametrised I2S / TDM transmit master.
// A FIFO buffers pushed samples. sclk and ws are derived from clk.
// sd is serialised MSB-first, and sd/ws change only on sclk falling edges.
// A frame starts only when a full frame of samples is buffered; otherwise
// the frame is muted and underrun pulses.
// Optional build macro I2S_TX_LEFT_JUSTIFIED_EN adds the leftJustified input
// (zero-bit ws delay). Without the macro the block is always standard I2S.
module i2s_tx_master_tdm #(
  parameter int DATA_WIDTH     = 8,
  parameter int SLOT_WIDTH     = 8,
  parameter int NUM_OF_CHANNEL = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int CLK_DIV        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  input  logic                             leftJustified,
`endif
  input  logic [DATA_WIDTH-1:0]            txData,
  input  logic                             txValid,
  output logic                             txReady,
  output logic                             sclk,
  output logic                             ws,
  output logic                             sd,
  output logic                             busy,
  output logic                             underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifoLevel
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int POS_W  = $clog2(SLOT_WIDTH);
  localparam int SLOT_W = $clog2(NUM_OF_CHANNEL);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_FRAME = LVL_W'(NUM_OF_CHANNEL);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_OF_CHANNEL - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(NUM_OF_CHANNEL / 2);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg;
  logic [DIV_W-1:0]        div_cnt_reg;
  logic                    sclk_reg, ws_reg, sd_reg, underrun_reg;
  logic [POS_W-1:0]        pos_reg, pos_next;
  logic [SLOT_W-1:0]       slot_reg, slot_next, slot_ws;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    frame_valid_reg;

  logic active, div_tc, fall, start, wrap, stop_now, do_update;
  logic frame_start, frame_ok, frame_valid_now, push, pop, ws_next, lj_eff;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  logic lj_reg;
  // Justification mode is latched while idle so it cannot change mid-stream.
  always_ff @(posedge clk) begin
    if (rst)                    lj_reg <= 1'b0;
    else if (state_reg == IDLE) lj_reg <= leftJustified;
  end
  assign lj_eff = (state_reg == IDLE) ? leftJustified : lj_reg;
`else
  assign lj_eff = 1'b0;
`endif

  // Control decode: update points, bit position advance, frame gating, FSM.
  always_comb begin
    active      = (state_reg != IDLE);
    div_tc      = (div_cnt_reg == DIV_LAST);
    fall        = active && div_tc && sclk_reg;
    start       = (state_reg == IDLE) && enable;
    wrap        = fall && (pos_reg == POS_LAST) && (slot_reg == SLOT_LAST);
    // The frame also ends cleanly if enable drops right at its last bit.
    stop_now    = wrap && ((state_reg == STOP) || !enable);
    do_update   = start || (fall && !stop_now);
    pos_next    = '0;
    slot_next   = '0;
    if (!(start || wrap)) begin
      if (pos_reg == POS_LAST) begin
        slot_next = slot_reg + 1'b1;
      end else begin
        pos_next  = pos_reg + 1'b1;
        slot_next = slot_reg;
      end
    end
    frame_start     = (pos_next == '0) && (slot_next == '0);
    frame_ok        = (level_reg >= LVL_FRAME);
    frame_valid_now = frame_start ? frame_ok : frame_valid_reg;
    pop             = do_update && (pos_next == '0) && frame_valid_now;
    push            = txValid && (level_reg != LVL_FULL);
    // Standard I2S looks one bit ahead; left-justified uses the current slot.
    slot_ws = slot_next;
    if (!lj_eff && (pos_next == POS_LAST))
      slot_ws = (slot_next == SLOT_LAST) ? '0 : slot_next + 1'b1;
    ws_next = (slot_ws >= SLOT_HALF);
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (stop_now) state_next = IDLE;
               else if (!enable) state_next = STOP;
      STOP:    if (stop_now) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FIFO storage; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= txData;
  end

  // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Bit-clock divider: sclk toggles each time the counter reaches terminal count.
  always_ff @(posedge clk) begin
    if (rst || !active || stop_now) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (div_tc) begin
      div_cnt_reg <= '0;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Serialiser: at each update point load a sample at slot start or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg         <= '0;
      slot_reg        <= '0;
      shift_reg       <= '0;
      sd_reg          <= 1'b0;
      ws_reg          <= 1'b0;
      frame_valid_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      underrun_reg <= do_update && frame_start && !frame_ok;
      if (stop_now) begin
        pos_reg  <= '0;
        slot_reg <= '0;
        sd_reg   <= 1'b0;
        ws_reg   <= 1'b0;
      end else if (do_update) begin
        pos_reg  <= pos_next;
        slot_reg <= slot_next;
        ws_reg   <= ws_next;
        if (frame_start) frame_valid_reg <= frame_ok;
        if (pos_next == '0) begin
          if (frame_valid_now) begin
            sd_reg    <= fifo_mem[rd_ptr_reg][DATA_WIDTH-1];
            shift_reg <= {fifo_mem[rd_ptr_reg][DATA_WIDTH-2:0], 1'b0};
          end else begin
            sd_reg    <= 1'b0;
            shift_reg <= '0;
          end
        end else begin
          // Zeros shifted in become the padding bits of wider slots.
          sd_reg    <= shift_reg[DATA_WIDTH-1];
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign txReady   = (level_reg != LVL_FULL);
  assign fifoLevel = level_reg;
  assign sclk      = sclk_reg;
  assign ws        = ws_reg;
  assign sd        = sd_reg;
  assign busy      = active;
  assign underrun  = underrun_reg;

endmodule

// File: doc/i2s_tx_master_tdm.md
Name: i2s_tx_master_tdm

Overview:
- Parametrised I2S transmit master. Next generation of the fixed 8-bit, 2-channel transmitter.
- Generalised in sample width, slot width, channel count (TDM when NUM_OF_CHANNEL>2) and FIFO depth.
- Buffers samples from a valid/ready push port in a FIFO.
- Generates sclk/ws from the system clock and serialises sd MSB-first. Sits between the audio source and the I2S pins.

Parameters:
- DATA_WIDTH, 8: sample width in bits; legal 8..32.
- SLOT_WIDTH, 8: bits per channel slot; must be >= DATA_WIDTH. Unused LSB bits are sent as 0.
- NUM_OF_CHANNEL, 2: slots per frame; even, 2..8.
- FIFO_DEPTH, 4: sample FIFO entries; must be >= NUM_OF_CHANNEL.
- CLK_DIV, 2: clk cycles per sclk half-period; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  start/continue transmission; stop at frame end when low.
- txData  in  DATA_WIDTH  sample; channel order 0,1,..,N-1 repeating.
- txValid  in  1  txData valid.
- txReady  out  1  FIFO can accept; high = !full.
- sclk  out  1  serial bit clock.
- ws  out  1  word select.
- sd  out  1  serial data.
- busy  out  1  high while frames are being clocked.
- underrun  out  1  one-clk pulse when a frame is muted.
- fifoLevel  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset:
  - sclk=0, ws=0, sd=0, busy=0, underrun=0, fifoLevel=0, txReady=1.
  - FIFO flushed, divider and bit counters cleared, state=IDLE.
  - rst mid-frame aborts immediately on the next clk edge.
- Push:
  - A word is accepted when txValid && txReady.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop with the FIFO not full: level unchanged.
- Divider:
  - Counter 0..CLK_DIV-1 in RUN/STOP; sclk toggles at terminal count.
  - "Falling edge" means the clk cycle in which sclk goes 1->0; sd and ws update only there.
  - The first update point is the clk cycle of IDLE->RUN.
- Frame:
  - F = NUM_OF_CHANNEL*SLOT_WIDTH bits; bit index b runs 0..F-1, then wraps.
  - Slot s = b/SLOT_WIDTH; pos p = b%SLOT_WIDTH.
  - sd = sample[DATA_WIDTH-1-p] for p<DATA_WIDTH, else 0.
- ws (standard I2S, 1-bit delay):
  - ws at bit b = (slot of ((b+1) mod F)) >= NUM_OF_CHANNEL/2.
  - ws therefore changes one sclk before each half-frame MSB.
- Frame gating, evaluated at b=0:
  - If fifoLevel >= NUM_OF_CHANNEL, the frame is valid: one word is popped at each slot's p=0 update, then shifted.
  - Otherwise the frame is muted: sd=0 for all F bits, no pops, underrun pulses one clk.
  - Channel alignment is never lost.
- States:
  - IDLE: sclk=0, ws=0, sd=0. Goes to RUN when enable=1.
  - RUN: busy=1. If enable=0 at any point, go to STOP.
  - STOP: finishes the current frame. After the update for b=F-1 plus the following sclk high phase, sclk=0, ws=0, sd=0, busy=0, then IDLE.
  - enable re-asserted during STOP: ignored; restart from IDLE.
- Pushes are accepted in every state.

Optional Feature:
- Macro: I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: adds input port leftJustified (1 bit), sampled only in IDLE.
  - When 1: zero-bit delay, ws at bit b = (slot of b) >= NUM_OF_CHANNEL/2, so ws edges coincide with the MSB.
  - When 0: standard I2S.
- Undefined: port absent; standard I2S 1-bit delay always.

Test Plan:
- Reset check: assert rst 3 clks during RUN -> next clk: sclk=0, ws=0, sd=0, busy=0, fifoLevel=0, txReady=1.
- Basic stereo (defaults, CLK_DIV=2): push 0xA5,0x3C, enable=1.
  - sd per bit b0..7 = 1,0,1,0,0,1,0,1; b8..15 = 0,0,1,1,1,1,0,0.
  - ws=0 for b0..6, 1 for b7..14, 0 at b15.
  - sclk period = 4 clk; fifoLevel 2->0.
- Underrun: push only 0x11, enable=1 -> 16 bits of sd=0, underrun high exactly 1 clk at b=0, fifoLevel stays 1.
- TDM (NUM_OF_CHANNEL=4, SLOT_WIDTH=16, DATA_WIDTH=12): push 0xABC, 0x123, 0xFFF, 0x800.
  - Each slot carries the 12 bits MSB-first followed by 4 zeros.
  - ws=1 from b=31 to b=62, 0 otherwise.
- Stop mid-frame: deassert enable at b=5 -> bits continue through b=15, then sclk stays 0, busy falls, no further pops.
- Full FIFO: enable=0, push 5 words back-to-back -> txReady low after 4th acceptance, fifoLevel=4, 5th word not stored.
